uart_rx_core: RTL
=================

// Module: uart_rx_core
// PURPOSE
//  UART receiver, the counterpart of the UART_TX serializer path. Oversamples rx_in by a runtime prescale,
//  detects start, samples LSB-first data, optional parity, and checks the stop bit.
//  Presents a parallel byte with a 1-cycle data_valid pulse to the system side (RX clock domain).
// PARAMETERS
//  DATA_WIDTH   8   frame data bits
//  PRESCALE_W   6   width of prescale input
// PORTS
//  clk         in   1           RX oversampling clock
//  rst         in   1           asynchronous, active-low reset
//  rx_in       in   1           serial line, idle high; asynchronous to clk
//  prescale    in   PRESCALE_W  oversample ratio; legal 8, 16, 32 (others undefined)
//  par_en      in   1           1 = parity bit present
//  par_typ     in   1           0 = even, 1 = odd
//  p_data      out  DATA_WIDTH  last good received byte
//  data_valid  out  1           1-cycle pulse: p_data updated
//  par_err     out  1           1-cycle pulse: parity mismatch, frame dropped
//  stp_err     out  1           1-cycle pulse: stop bit sampled 0, frame dropped
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, synchronizer flops 1. Mid-frame reset aborts the frame
//    silently; no pulse is issued.
//  - rx_in passes through a 2-flop synchronizer (rx_s). All timing below is relative to rx_s.
//  - edge_cnt counts 0..prescale-1 within each bit. bit_cnt counts data bits 0..DATA_WIDTH-1.
//  - Sample point is mid = prescale>>1. The bit value is latched when edge_cnt == mid.
//  - par_en, par_typ and prescale are captured on IDLE->START. Changes mid-frame are ignored.
//  - FSM:
//    IDLE   : rx_s==0 -> START, edge_cnt=0.
//    START  : at sample, bit==1 -> IDLE (glitch, no pulse).
//             At edge_cnt==prescale-1 -> DATA.
//    DATA   : at sample, shift bit into shift reg LSB-first.
//             At bit end, after the DATA_WIDTH-th bit -> PARITY if par_en, else STOP.
//    PARITY : at sample, compare with ^data ^ par_typ and latch the mismatch flag.
//             At bit end -> STOP.
//    STOP   : at sample, latch stop value. At edge_cnt==prescale-1, on the next clk:
//             parity mismatch -> par_err=1 (par_err has priority; stp_err also set if stop==0);
//             else stop==0 -> stp_err=1;
//             else p_data <= shift reg and data_valid=1.
//             Next state is START (edge_cnt=0) if rx_s==0, else IDLE; back-to-back frames need no idle gap.
//  - On error, p_data holds its previous value.
//  - Latency: data_valid is asserted (1 + par_en + DATA_WIDTH + 1)*prescale cycles after the rx_s falling edge.
// CONFIGURATION
//  UART_RX_MAJORITY_EN
//    defined  : three samples at mid-1, mid, mid+1; the bit is the 2-of-3 majority, decided at edge_cnt==mid+1.
//               Applies to the start check too. Rejects single-clock glitches.
//    undefined: single sample at mid; glitch at mid corrupts the bit. Less logic.
// TESTING
//  1. prescale=8, par_en=1, par_typ=0; send 0xA5, parity 0, stop 1
//     -> data_valid pulse 88 cycles after rx_s fall, p_data=0xA5, no errors.
//  2. As 1 but parity bit=1 -> par_err 1 cycle, data_valid stays 0, p_data unchanged (0xA5).
//  3. prescale=16, par_en=0; 0x3C with stop=0 -> stp_err 1 cycle, no data_valid.
//  4. prescale=16; rx_in low for 3 cycles then high -> FSM back to IDLE, no pulses.
//     A following valid 0x55 is received correctly.
//  5. prescale=32, par_en=0; frames 0xC3 then 0x3C back-to-back, no idle
//     -> two data_valid pulses 320 cycles apart, correct data.
//  6. rst low during DATA bit 4 -> all outputs 0 immediately; next frame 0x81 -> data_valid, p_data=0x81.
//     With UART_RX_MAJORITY_EN, a 1-clk inverted glitch at mid of bit 2 of 0x00 -> p_data=0x00.

Source files
------------

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// UART receiver that pairs with the UART_TX serializer. It oversamples the
// serial line by a runtime prescale, finds the start bit, shifts in the data
// bits LSB-first, optionally checks a parity bit and finally checks the stop
// bit. A good frame updates p_data together with a one-cycle data_valid
// pulse. Frames with a bad parity or stop bit are dropped and reported with
// a one-cycle error pulse instead.
//
// Parameters
//   DATA_WIDTH  data bits per frame (default 8)
//   PRESCALE_W  width of the prescale input (default 6)
//
// Ports
//   clk         in   oversampling clock
//   rst         in   asynchronous reset, active low
//   rx_in       in   serial line, idle high, asynchronous to clk
//   prescale    in   oversample ratio (8, 16 or 32)
//   par_en      in   1 = frame carries a parity bit
//   par_typ     in   0 = even parity, 1 = odd parity
//   p_data      out  last correctly received data word
//   data_valid  out  one-cycle pulse, p_data has just been updated
//   par_err     out  one-cycle pulse, parity mismatch, frame dropped
//   stp_err     out  one-cycle pulse, stop bit sampled low, frame dropped
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every bit (start bit included) is the
//                        2-of-3 majority of the samples at mid-1, mid and
//                        mid+1, which rejects single-clock glitches. When
//                        undefined, a single sample at mid is taken.
//
// Bit timing
//   All timing is relative to the synchronized line rx_s. The cycle in which
//   IDLE first sees rx_s low is edge 0 of the start bit, so the FSM's bit
//   boundaries line up exactly with the bit boundaries on rx_s and the
//   data_valid pulse appears (1 + par_en + DATA_WIDTH + 1) * prescale cycles
//   after the rx_s falling edge.
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // 2-of-3 vote used when majority sampling is enabled.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic                  sync1_q;
    logic                  rx_s_q;

    state_t                state_q,      state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q,   edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [PRESCALE_W-1:0] pre_q,        pre_d;
    logic                  par_en_q,     par_en_d;
    logic                  par_typ_q,    par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic                  par_mis_q,    par_mis_d;
    logic                  stop_bit_q,   stop_bit_d;
    logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q,    par_err_d;
    logic                  stp_err_q,    stp_err_d;

    // -------------------------------------------------------------------------
    // Per-bit timing helpers
    // -------------------------------------------------------------------------
    logic [PRESCALE_W-1:0] mid;
    logic                  last_edge;
    logic                  sample_hit;
    logic                  sample_bit;

    assign mid       = pre_q >> 1;
    assign last_edge = (edge_cnt_q == (pre_q - EDGE_ONE));

`ifdef UART_RX_MAJORITY_EN
    // maj_q[0] holds the sample at mid-1, maj_q[1] the sample at mid; the
    // third vote is the live line at mid+1, where the decision is made.
    logic [1:0] maj_q, maj_d;

    always_comb begin
        maj_d = maj_q;
        if (edge_cnt_q == (mid - EDGE_ONE)) begin
            maj_d[0] = rx_s_q;
        end
        if (edge_cnt_q == mid) begin
            maj_d[1] = rx_s_q;
        end
    end

    assign sample_hit = (edge_cnt_q == (mid + EDGE_ONE));
    assign sample_bit = maj3(maj_q[0], maj_q[1], rx_s_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= maj_d;
        end
    end
`else
    assign sample_hit = (edge_cnt_q == mid);
    assign sample_bit = rx_s_q;
`endif

    // -------------------------------------------------------------------------
    // Input synchronizer (rx_in is asynchronous to clk); resets to idle-high
    // so a reset never looks like a start bit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q + EDGE_ONE;
        bit_cnt_d    = bit_cnt_q;
        pre_d        = pre_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shift_d      = shift_q;
        par_mis_d    = par_mis_q;
        stop_bit_d   = stop_bit_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    // This cycle is edge 0 of the start bit. Frame settings
                    // are frozen here so mid-frame changes have no effect.
                    state_d    = S_START;
                    edge_cnt_d = EDGE_ONE;
                    bit_cnt_d  = '0;
                    pre_d      = prescale;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                    par_mis_d  = 1'b0;
                end
            end

            S_START: begin
                if (sample_hit && sample_bit) begin
                    // Line went back high: treat it as a glitch.
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (last_edge) begin
                    state_d    = S_DATA;
                    edge_cnt_d = '0;
                end
            end

            S_DATA: begin
                if (sample_hit) begin
                    shift_d = {sample_bit, shift_q[DATA_WIDTH-1:1]};
                end
                if (last_edge) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end

            S_PARITY: begin
                if (sample_hit) begin
                    // Expected bit is ^data for even, ~^data for odd.
                    par_mis_d = sample_bit ^ (^shift_q) ^ par_typ_q;
                end
                if (last_edge) begin
                    state_d    = S_STOP;
                    edge_cnt_d = '0;
                end
            end

            S_STOP: begin
                if (sample_hit) begin
                    stop_bit_d = sample_bit;
                end
                if (last_edge) begin
                    edge_cnt_d = '0;
                    if (par_mis_q) begin
                        // Parity error wins; a bad stop bit is flagged as well.
                        par_err_d = 1'b1;
                        stp_err_d = ~stop_bit_q;
                    end else if (!stop_bit_q) begin
                        stp_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end

                    if (!rx_s_q) begin
                        // Line already low: start the next frame right away.
                        state_d   = S_START;
                        bit_cnt_d = '0;
                        pre_d     = prescale;
                        par_en_d  = par_en;
                        par_typ_d = par_typ;
                        par_mis_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            pre_q        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
            stop_bit_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            pre_q        <= pre_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shift_q      <= shift_d;
            par_mis_q    <= par_mis_d;
            stop_bit_q   <= stop_bit_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
